// File: rtl/rf_pkg.sv
// Shared constants and bus-slicing helpers for the physical register file.
package rf_pkg;

  localparam int unsigned RF_XLEN      = 32;
  localparam int unsigned RF_AWIDTH    = 6;
  localparam int unsigned RF_ZERO_ADDR = 0;

  // LSB offset of field idx in a flattened bus of width-bit fields.
  function automatic int unsigned slice_lo(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

  // MSB offset of field idx in a flattened bus of width-bit fields.
  function automatic int unsigned slice_hi(int unsigned idx, int unsigned width);
    return (idx + 1) * width - 1;
  endfunction

endpackage

// File: rtl/regfile_wprio.sv
// Looks up one address against all write ports; the highest-index matching port wins.
module regfile_wprio
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned AWIDTH = RF_AWIDTH,
  parameter int unsigned NWRITE = 4
) (
  input  logic [NWRITE-1:0]        i_we,
  input  logic [NWRITE*AWIDTH-1:0] i_waddr,
  input  logic [NWRITE*XLEN-1:0]   i_wdata,
  input  logic [AWIDTH-1:0]        i_addr,
  output logic                     o_hit,
  output logic [XLEN-1:0]          o_wdata
);

  // Ascending scan: a later match overrides, so the highest index wins.
  always_comb begin
    o_hit   = 1'b0;
    o_wdata = '0;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (i_we[j] && (i_waddr[slice_lo(j, AWIDTH) +: AWIDTH] == i_addr)) begin
        o_hit   = 1'b1;
        o_wdata = i_wdata[slice_lo(j, XLEN) +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port physical register file with per-entry ready bits, hardwired zero
// register, highest-index write priority and optional write-to-read bypass.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned AWIDTH = RF_AWIDTH,
  parameter int unsigned NREAD  = 8,
  parameter int unsigned NWRITE = 4,
  parameter int unsigned NCLR   = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREAD*AWIDTH-1:0]  i_raddr,
  output logic [NREAD*XLEN-1:0]    o_rdata,
  output logic [NREAD-1:0]         o_rready,
  input  logic [NWRITE-1:0]        i_we,
  input  logic [NWRITE*AWIDTH-1:0] i_waddr,
  input  logic [NWRITE*XLEN-1:0]   i_wdata,
  input  logic [NCLR-1:0]          i_clr,
  input  logic [NCLR*AWIDTH-1:0]   i_clr_addr
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] ZeroAddr = AWIDTH'(RF_ZERO_ADDR);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [XLEN-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0] rdy_q;
  logic [DEPTH-1:0] rdy_d;

  logic [DEPTH-1:0] wr_hit;
  logic [XLEN-1:0]  wr_data [DEPTH];
  logic [DEPTH-1:0] clr_hit;

  // Per-entry write decode.
  for (genvar e = 0; e < DEPTH; e++) begin : g_wdec
    regfile_wprio #(
      .XLEN   (XLEN),
      .AWIDTH (AWIDTH),
      .NWRITE (NWRITE)
    ) u_wdec (
      .i_we    (i_we),
      .i_waddr (i_waddr),
      .i_wdata (i_wdata),
      .i_addr  (AWIDTH'(e)),
      .o_hit   (wr_hit[e]),
      .o_wdata (wr_data[e])
    );
  end

  always_comb begin
    clr_hit = '0;
    for (int unsigned c = 0; c < NCLR; c++) begin
      if (i_clr[c]) begin
        clr_hit[i_clr_addr[slice_lo(c, AWIDTH) +: AWIDTH]] = 1'b1;
      end
    end
  end

  // Clear beats write for the ready bit; the data write still lands.
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
      rdy_d[e] = rdy_q[e];
      if (wr_hit[e]) begin
        mem_d[e] = wr_data[e];
        rdy_d[e] = 1'b1;
      end
      if (clr_hit[e]) begin
        rdy_d[e] = 1'b0;
      end
    end
    mem_d[0] = '0;
    rdy_d[0] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
      rdy_q <= '1;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
      rdy_q <= rdy_d;
    end
  end

  logic [AWIDTH-1:0] rd_addr  [NREAD];
  logic [NREAD-1:0]  byp_hit;
  logic [XLEN-1:0]   byp_data [NREAD];

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    assign rd_addr[k] = i_raddr[k*AWIDTH +: AWIDTH];

    regfile_wprio #(
      .XLEN   (XLEN),
      .AWIDTH (AWIDTH),
      .NWRITE (NWRITE)
    ) u_byp (
      .i_we    (i_we),
      .i_waddr (i_waddr),
      .i_wdata (i_wdata),
      .i_addr  (rd_addr[k]),
      .o_hit   (byp_hit[k]),
      .o_wdata (byp_data[k])
    );
  end

  // Bypass forwards write data only; same-cycle clears show up next cycle.
  always_comb begin
    o_rdata  = '0;
    o_rready = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (rd_addr[k] == ZeroAddr) begin
        o_rdata[slice_lo(k, XLEN) +: XLEN] = '0;
        o_rready[k]                        = 1'b1;
      end else if ((BYPASS != 0) && !i_rst && byp_hit[k]) begin
        o_rdata[slice_lo(k, XLEN) +: XLEN] = byp_data[k];
        o_rready[k]                        = 1'b1;
      end else begin
        o_rdata[slice_lo(k, XLEN) +: XLEN] = mem_q[rd_addr[k]];
        o_rready[k]                        = rdy_q[rd_addr[k]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances against an array model.
module tb_regfile_mp;

  localparam int XL = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam int NW = 4;
  localparam int NC = 4;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic           rst;
  logic [NW-1:0]  we;
  logic [AW-1:0]  waddr [NW];
  logic [XL-1:0]  wdata [NW];
  logic [NC-1:0]  clr;
  logic [AW-1:0]  caddr [NC];
  logic [AW-1:0]  raddr [NR];

  logic [NR*AW-1:0] raddr_bus;
  logic [NW*AW-1:0] waddr_bus;
  logic [NW*XL-1:0] wdata_bus;
  logic [NC*AW-1:0] caddr_bus;

  always_comb begin
    raddr_bus = '0;
    waddr_bus = '0;
    wdata_bus = '0;
    caddr_bus = '0;
    for (int k = 0; k < NR; k++) raddr_bus[k*AW +: AW] = raddr[k];
    for (int j = 0; j < NW; j++) begin
      waddr_bus[j*AW +: AW] = waddr[j];
      wdata_bus[j*XL +: XL] = wdata[j];
    end
    for (int c = 0; c < NC; c++) caddr_bus[c*AW +: AW] = caddr[c];
  end

  logic [NR*XL-1:0] rdata1, rdata0;
  logic [NR-1:0]    rready1, rready0;

  regfile_mp #(.XLEN(XL), .AWIDTH(AW), .NREAD(NR), .NWRITE(NW), .NCLR(NC), .BYPASS(1)) u_dut_byp (
    .i_clk      (i_clk),
    .i_rst      (rst),
    .i_raddr    (raddr_bus),
    .o_rdata    (rdata1),
    .o_rready   (rready1),
    .i_we       (we),
    .i_waddr    (waddr_bus),
    .i_wdata    (wdata_bus),
    .i_clr      (clr),
    .i_clr_addr (caddr_bus)
  );

  regfile_mp #(.XLEN(XL), .AWIDTH(AW), .NREAD(NR), .NWRITE(NW), .NCLR(NC), .BYPASS(0)) u_dut_nobyp (
    .i_clk      (i_clk),
    .i_rst      (rst),
    .i_raddr    (raddr_bus),
    .o_rdata    (rdata0),
    .o_rready   (rready0),
    .i_we       (we),
    .i_waddr    (waddr_bus),
    .i_wdata    (wdata_bus),
    .i_clr      (clr),
    .i_clr_addr (caddr_bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Architectural state of the register file.
  logic [XL-1:0] m_mem [64];
  bit            m_rdy [64];

  always @(posedge i_clk) begin
    if (rst) begin
      for (int e = 0; e < 64; e++) begin
        m_mem[e] = '0;
        m_rdy[e] = 1'b1;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && waddr[j] != 0) begin
          m_mem[waddr[j]] = wdata[j];
          m_rdy[waddr[j]] = 1'b1;
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (clr[c] && caddr[c] != 0) m_rdy[caddr[c]] = 1'b0;
      end
    end
  end

  function automatic void model_read(input int a, input bit byp,
                                     output logic [XL-1:0] d, output logic r);
    d = m_mem[a];
    r = m_rdy[a];
    if (a == 0) begin
      d = '0;
      r = 1'b1;
    end else if (byp && !rst) begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && int'(waddr[j]) == a) begin
          d = wdata[j];
          r = 1'b1;
        end
      end
    end
  endfunction

  always @(negedge i_clk) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        logic [XL-1:0] ed1, ed0;
        logic er1, er0;
        model_read(int'(raddr[k]), 1'b1, ed1, er1);
        model_read(int'(raddr[k]), 1'b0, ed0, er0);
        checks += 4;
        if (rdata1[k*XL +: XL] !== ed1) begin
          failures++;
          $display("FAIL model_rdata_byp t=%0t port=%0d addr=%0d got=%h exp=%h",
                   $time, k, raddr[k], rdata1[k*XL +: XL], ed1);
        end
        if (rready1[k] !== er1) begin
          failures++;
          $display("FAIL model_rready_byp t=%0t port=%0d addr=%0d got=%b exp=%b",
                   $time, k, raddr[k], rready1[k], er1);
        end
        if (rdata0[k*XL +: XL] !== ed0) begin
          failures++;
          $display("FAIL model_rdata_nobyp t=%0t port=%0d addr=%0d got=%h exp=%h",
                   $time, k, raddr[k], rdata0[k*XL +: XL], ed0);
        end
        if (rready0[k] !== er0) begin
          failures++;
          $display("FAIL model_rready_nobyp t=%0t port=%0d addr=%0d got=%b exp=%b",
                   $time, k, raddr[k], rready0[k], er0);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
    rst = 1'b0;
    we  = '0;
    clr = '0;
  endtask

  task automatic neg();
    @(negedge i_clk);
  endtask

  initial begin
    rst = 1'b1;
    we  = '0;
    clr = '0;
    for (int j = 0; j < NW; j++) begin
      waddr[j] = '0;
      wdata[j] = '0;
    end
    for (int c = 0; c < NC; c++) caddr[c] = '0;
    for (int k = 0; k < NR; k++) raddr[k] = '0;
    @(posedge i_clk);
    #1;
    chk_en = 1'b1;

    // Reset clears a written entry; reads during the reset cycle see stored data.
    cyc(); we[0] = 1'b1; waddr[0] = 6'd5; wdata[0] = 32'hDEADBEEF;
    cyc(); raddr[0] = 6'd5;
    neg(); lit("rst_pre_write", rdata1[0 +: XL], 32'hDEADBEEF);
    cyc(); rst = 1'b1;
    neg(); lit("rst_cycle_stored", rdata1[0 +: XL], 32'hDEADBEEF);
    cyc();
    neg(); lit("rst_after_data", rdata1[0 +: XL], 32'h0);
           lit("rst_after_rdy", 32'(rready1[0]), 32'h1);
    for (int b = 0; b < 8; b++) begin
      cyc();
      for (int k = 0; k < NR; k++) raddr[k] = 6'(b * 8 + k);
      neg();
      for (int k = 0; k < NR; k++) begin
        lit("rst_all_data", rdata1[k*XL +: XL] | rdata0[k*XL +: XL], 32'h0);
        lit("rst_all_rdy", 32'(rready1[k] & rready0[k]), 32'h1);
      end
    end

    // Basic write with and without bypass.
    cyc(); we[0] = 1'b1; waddr[0] = 6'd3; wdata[0] = 32'h12345678; raddr[0] = 6'd3;
    neg(); lit("wr_byp_same", rdata1[0 +: XL], 32'h12345678);
           lit("wr_nobyp_same", rdata0[0 +: XL], 32'h0);
    cyc();
    neg(); lit("wr_byp_next", rdata1[0 +: XL], 32'h12345678);
           lit("wr_nobyp_next", rdata0[0 +: XL], 32'h12345678);

    // Conflict: port 3 beats port 1.
    cyc(); we[1] = 1'b1; waddr[1] = 6'd7; wdata[1] = 32'h11;
           we[3] = 1'b1; waddr[3] = 6'd7; wdata[3] = 32'h33; raddr[0] = 6'd7;
    neg(); lit("conf_byp", rdata1[0 +: XL], 32'h33);
           lit("conf_nobyp_old", rdata0[0 +: XL], 32'h0);
    cyc();
    neg(); lit("conf_stored_byp", rdata1[0 +: XL], 32'h33);
           lit("conf_stored_nobyp", rdata0[0 +: XL], 32'h33);

    // Zero register ignores writes and clears.
    cyc(); we[0] = 1'b1; waddr[0] = 6'd0; wdata[0] = 32'hFFFFFFFF;
           clr[0] = 1'b1; caddr[0] = 6'd0; raddr[0] = 6'd0;
    neg(); lit("zero_byp_data", rdata1[0 +: XL], 32'h0);
           lit("zero_byp_rdy", 32'(rready1[0]), 32'h1);
    cyc();
    neg(); lit("zero_next_data", rdata0[0 +: XL], 32'h0);
           lit("zero_next_rdy", 32'(rready0[0]), 32'h1);

    // Ready tracking on reg 9.
    cyc(); clr[0] = 1'b1; caddr[0] = 6'd9; raddr[0] = 6'd9;
    neg(); lit("clr_same_rdy", 32'(rready1[0]), 32'h1);
    cyc();
    neg(); lit("clr_next_rdy_byp", 32'(rready1[0]), 32'h0);
           lit("clr_next_rdy_nobyp", 32'(rready0[0]), 32'h0);
    cyc();
    cyc(); we[0] = 1'b1; waddr[0] = 6'd9; wdata[0] = 32'hAB;
    neg(); lit("rdy_wr_byp_data", rdata1[0 +: XL], 32'hAB);
           lit("rdy_wr_byp_rdy", 32'(rready1[0]), 32'h1);
           lit("rdy_wr_nobyp_rdy", 32'(rready0[0]), 32'h0);
    cyc();
    neg(); lit("rdy_set_data", rdata0[0 +: XL], 32'hAB);
           lit("rdy_set_rdy", 32'(rready0[0]), 32'h1);
    cyc(); we[0] = 1'b1; waddr[0] = 6'd9; wdata[0] = 32'hCD; clr[1] = 1'b1; caddr[1] = 6'd9;
    neg(); lit("wrclr_byp_data", rdata1[0 +: XL], 32'hCD);
           lit("wrclr_byp_rdy", 32'(rready1[0]), 32'h1);
    cyc();
    neg(); lit("wrclr_next_data", rdata0[0 +: XL], 32'hCD);
           lit("wrclr_next_rdy", 32'(rready0[0] | rready1[0]), 32'h0);

    // Reset with every write and clear port active.
    cyc(); rst = 1'b1;
    for (int j = 0; j < NW; j++) begin
      we[j] = 1'b1; waddr[j] = 6'(j + 1); wdata[j] = 32'hA0 + 32'(j);
    end
    for (int c = 0; c < NC; c++) begin
      clr[c] = 1'b1; caddr[c] = 6'(c + 5);
    end
    for (int k = 0; k < NR; k++) raddr[k] = 6'(k + 1);
    neg(); lit("rstmid_nobyp_a3", rdata1[2*XL +: XL], 32'h12345678);
           lit("rstmid_nobyp_a1", rdata1[0 +: XL], 32'h0);
    cyc();
    neg();
    for (int k = 0; k < NR; k++) begin
      lit("rstmid_after_data", rdata1[k*XL +: XL] | rdata0[k*XL +: XL], 32'h0);
      lit("rstmid_after_rdy", 32'(rready1[k] & rready0[k]), 32'h1);
    end

    // Randomised traffic concentrated on a few addresses to provoke conflicts.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(0, 63) == 0);
      for (int j = 0; j < NW; j++) begin
        we[j]    = $urandom_range(0, 1) == 1;
        waddr[j] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 15));
        wdata[j] = $urandom;
      end
      for (int c = 0; c < NC; c++) begin
        clr[c]   = $urandom_range(0, 3) == 0;
        caddr[c] = 6'($urandom_range(0, 15));
      end
      for (int k = 0; k < NR; k++) begin
        raddr[k] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 15));
      end
    end

    cyc();
    neg();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
